// File: rtl/fetch_buffer_if.sv
// Fetch-side bundle: PC handshake with program_counter, instruction memory port, decode stream.
// master is the fetch buffer itself; slave is the surrounding core/testbench.
interface fetch_buffer_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] pc;
  logic             pc_en;
  logic             redirect;
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic [31:0]      imem_rdata;
  logic             if_valid;
  logic             if_ready;
  logic [31:0]      if_instr;
  logic [WIDTH-1:0] if_pc;
  logic [CntW-1:0]  count;

  modport master (
    input  pc, redirect, imem_rdata, if_ready,
    output pc_en, imem_req, imem_addr, if_valid, if_instr, if_pc, count
  );

  modport slave (
    output pc, redirect, imem_rdata, if_ready,
    input  pc_en, imem_req, imem_addr, if_valid, if_instr, if_pc, count
  );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction-fetch front end: issues PC to a 1-cycle memory, queues {pc, instr} pairs in a
// credit-controlled FIFO and streams them to decode; redirect flushes everything in flight.
module fetch_buffer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  fetch_buffer_if.master bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0] DepthC = DEPTH[CntW:0];

  logic [CntW-1:0]  count_q, count_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic             inflight_q;
  logic             kill_q;
  logic [WIDTH-1:0] req_pc_q;
  logic [WIDTH-1:0] pc_mem_q    [DEPTH];
  logic [31:0]      instr_mem_q [DEPTH];

  logic [CntW:0] credits_used;
  logic          issue;
  logic          push;
  logic          pop;
  logic          if_valid;

  // Credits come from registered state only, so a same-cycle pop never frees a slot early and a
  // returning response always finds room.
  assign credits_used = {1'b0, count_q} + {{CntW{1'b0}}, inflight_q};
  assign issue        = rst_ni & ~bus.redirect & (credits_used < DepthC);
  assign push         = inflight_q & ~kill_q & ~bus.redirect;
  assign if_valid     = (count_q != '0) & ~bus.redirect;
  assign pop          = if_valid & bus.if_ready;

  assign bus.imem_req  = issue;
  assign bus.imem_addr = bus.pc;
  assign bus.pc_en     = rst_ni & (issue | bus.redirect);
  assign bus.if_valid  = if_valid;
  assign bus.if_instr  = instr_mem_q[rd_ptr_q];
  assign bus.if_pc     = pc_mem_q[rd_ptr_q];
  assign bus.count     = count_q;

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (bus.redirect) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
      req_pc_q   <= '0;
    end else begin
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      inflight_q <= issue;
      kill_q     <= bus.redirect;
      if (issue) req_pc_q <= bus.pc;
    end
  end

  // Payload storage needs no reset: count gates visibility of every entry.
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= req_pc_q;
      instr_mem_q[wr_ptr_q] <= bus.imem_rdata;
    end
  end
endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: queue-based reference model, directed scenarios, then random traffic.
module tb_fetch_buffer;
  localparam int unsigned Width = 32;
  localparam int unsigned Depth = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] target;
  logic [31:0] key;

  int   n_tests;
  int   n_fail;
  ent_t q[$];
  bit   m_infl;
  logic [31:0] m_req_pc;
  logic [31:0] m_pc;

  fetch_buffer_if #(.WIDTH(Width), .DEPTH(Depth)) bus ();

  fetch_buffer #(.WIDTH(Width), .DEPTH(Depth)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ key;
  endfunction

  // Environment: program counter and a 1-cycle memory that returns garbage when not requested.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.pc <= '0;
    else if (bus.pc_en) bus.pc <= bus.redirect ? target : bus.pc + 32'd4;
  end

  always_ff @(posedge clk) begin
    bus.imem_rdata <= bus.imem_req ? instr_of(bus.imem_addr) : $urandom;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_infl   = 1'b0;
    m_req_pc = '0;
    m_pc     = '0;
  endtask

  // One clock cycle: drive, check against the model, advance the model, cross the edge.
  task automatic tick(input bit ready, input bit redir, input logic [31:0] tgt);
    bit exp_issue;
    bit exp_valid;
    bus.if_ready = ready;
    bus.redirect = redir;
    target       = tgt;
    #1;
    exp_issue = !redir && (q.size() + int'(m_infl) < Depth);
    exp_valid = (q.size() != 0) && !redir;
    chk("pc", bus.pc, m_pc);
    chk("imem_req", bus.imem_req, exp_issue);
    chk("pc_en", bus.pc_en, exp_issue | redir);
    if (exp_issue) chk("imem_addr", bus.imem_addr, m_pc);
    chk("if_valid", bus.if_valid, exp_valid);
    chk("count", bus.count, q.size());
    if (exp_valid) begin
      chk("if_pc", bus.if_pc, q[0].pc);
      chk("if_instr", bus.if_instr, q[0].instr);
    end
    if (redir) begin
      q.delete();
      m_infl = 1'b0;
      m_pc   = tgt;
    end else begin
      if (exp_valid && ready) void'(q.pop_front());
      if (m_infl) q.push_back('{pc: m_req_pc, instr: instr_of(m_req_pc)});
      m_infl = exp_issue;
      if (exp_issue) begin
        m_req_pc = m_pc;
        m_pc     = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.if_ready = 1'b0;
    bus.redirect = 1'b0;
    target       = '0;
    model_clear();
    #1;
    chk("rst_count", bus.count, 0);
    chk("rst_if_valid", bus.if_valid, 0);
    chk("rst_imem_req", bus.imem_req, 0);
    chk("rst_pc_en", bus.pc_en, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    key     = $urandom;

    // Streaming from reset: one instruction per cycle from cycle 2.
    do_reset();
    repeat (2) tick(1'b1, 1'b0, '0);
    chk("t1_valid", bus.if_valid, 1);
    chk("t1_pc0", bus.if_pc, 32'h0);
    chk("t1_instr0", bus.if_instr, instr_of(32'h0));
    tick(1'b1, 1'b0, '0);
    chk("t1_pc1", bus.if_pc, 32'h4);
    tick(1'b1, 1'b0, '0);
    chk("t1_pc2", bus.if_pc, 32'h8);

    // Stalled decode: exactly DEPTH fetches, then PC holds.
    do_reset();
    repeat (6) tick(1'b0, 1'b0, '0);
    chk("t2_pc", bus.pc, 32'h10);
    chk("t2_count", bus.count, 4);
    chk("t2_valid", bus.if_valid, 1);
    chk("t2_pc_en", bus.pc_en, 0);
    // One pop frees a credit only on the following cycle.
    tick(1'b1, 1'b0, '0);
    chk("t3_count", bus.count, 3);
    chk("t3_issue", bus.imem_req, 1);
    chk("t3_addr", bus.imem_addr, 32'h10);
    chk("t3_head", bus.if_pc, 32'h4);

    // Redirect with a response in flight and two entries queued.
    do_reset();
    repeat (3) tick(1'b0, 1'b0, '0);
    chk("t4_pre_count", bus.count, 2);
    tick(1'b0, 1'b1, 32'h100);
    chk("t4_count", bus.count, 0);
    chk("t4_pc", bus.pc, 32'h100);
    repeat (2) tick(1'b0, 1'b0, '0);
    chk("t4_valid", bus.if_valid, 1);
    chk("t4_if_pc", bus.if_pc, 32'h100);
    chk("t4_instr", bus.if_instr, instr_of(32'h100));

    // Simultaneous push and pop at count 3.
    do_reset();
    repeat (4) tick(1'b0, 1'b0, '0);
    chk("t5_pre_count", bus.count, 3);
    chk("t5_pre_head", bus.if_pc, 32'h0);
    tick(1'b1, 1'b0, '0);
    chk("t5_count", bus.count, 3);
    chk("t5_head", bus.if_pc, 32'h4);

    // Asynchronous reset while a response is in flight.
    do_reset();
    repeat (5) tick(1'b1, 1'b0, '0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_req", bus.imem_req, 0);
    chk("t6_pc_en", bus.pc_en, 0);
    chk("t6_valid", bus.if_valid, 0);
    chk("t6_count", bus.count, 0);
    model_clear();
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (4) tick(1'b1, 1'b0, '0);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 500; i++) begin
      tick(($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0),
           32'($urandom_range(0, 1023)) << 2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
